// File: rtl/pwm_peripheral_if.sv
// Config-register and pin bundle between the SPI register bank and the PWM peripheral.
// The master side owns the enables and duty; the peripheral drives the pins.
interface pwm_peripheral_if #(
    parameter int NUM_OUT = 16
);
    logic [NUM_OUT-1:0] en_out;
    logic [NUM_OUT-1:0] en_pwm;
    logic [7:0]         duty;
    logic [NUM_OUT-1:0] out;
    logic               period_start;

    modport master (
        output en_out,
        output en_pwm,
        output duty,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_out,
        input  en_pwm,
        input  duty,
        output out,
        output period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// Shared 8-bit PWM with a clock divider and double-buffered duty.
// Drives NUM_OUT pins, each forced low, static high or PWM.
module pwm_peripheral #(
    parameter int CLK_DIV = 13,
    parameter int NUM_OUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_peripheral_if.slave  bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic [7:0]       pwm_cnt;
    logic [7:0]       cnt_next;
    logic [7:0]       duty_active;
    logic [7:0]       duty_next;
    logic             tick;
    logic             wrap;
    logic             pwm_sig_next;

    // The pins are registered from the counter/duty values of the coming
    // cycle, so PWM edges land on the same clk as period_start.
    always_comb begin
        tick         = (div_cnt == DIV_W'(CLK_DIV - 1));
        wrap         = tick && (pwm_cnt == 8'hFF);
        div_next     = tick ? '0 : div_cnt + DIV_W'(1);
        cnt_next     = tick ? pwm_cnt + 8'd1 : pwm_cnt;
        duty_next    = wrap ? bus.duty : duty_active;
        pwm_sig_next = (duty_next == 8'hFF) | (cnt_next < duty_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt          <= '0;
            pwm_cnt          <= 8'h00;
            duty_active      <= 8'h00;
            bus.period_start <= 1'b0;
            bus.out          <= '0;
        end else begin
            div_cnt          <= div_next;
            pwm_cnt          <= cnt_next;
            duty_active      <= duty_next;
            bus.period_start <= wrap;
            bus.out          <= bus.en_out & (~bus.en_pwm | {NUM_OUT{pwm_sig_next}});
        end
    end
endmodule
